// File: rtl/bfm_sched_pkg.sv
// Shared types and sizing helpers for the bfm transmit scheduler.
package bfm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XMIT = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  // Width of a burst-length field able to hold 0..max_burst.
  function automatic int len_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the lowest requester above last_gnt wins,
// wrapping back to index 0 when nothing above it is requesting.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last_gnt,
  output logic [NUM_REQ-1:0] gnt
);

  logic [NUM_REQ-1:0] above;
  logic [NUM_REQ-1:0] masked;
  logic               seen;
  logic               found;

  always_comb begin
    above = '0;
    seen  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      above[i] = seen;
      if (last_gnt[i]) seen = 1'b1;
    end
    masked = req & above;

    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && masked[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bfm_xmit_sched.sv
// Burst scheduler: grants one requester at a time round-robin and streams its
// operand pairs into registered A_s/B_s for the bfm datapath.
//
//   state | meaning
//   IDLE  | waiting; samples req_i and latches winner and burst length
//   XMIT  | granted requester streams pairs, count runs down to zero
//   DONE  | one-cycle completion pulse, winner becomes last_gnt
module bfm_xmit_sched
  import bfm_sched_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int ITEM_WIDTH = 8,
  parameter  int MAX_BURST  = 100,
  localparam int LEN_W      = len_width(MAX_BURST)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*LEN_W-1:0]      len_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  input  logic [NUM_REQ-1:0]            item_valid_i,
  input  logic [NUM_REQ*ITEM_WIDTH-1:0] item_a_i,
  input  logic [NUM_REQ*ITEM_WIDTH-1:0] item_b_i,
  output logic [NUM_REQ-1:0]            item_ready_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [ITEM_WIDTH-1:0]         A_s,
  output logic [ITEM_WIDTH-1:0]         B_s,
  output logic                          dp_valid_o,
  output logic                          busy_o
);

  localparam logic [NUM_REQ-1:0] LAST_RST = NUM_REQ'(1) << (NUM_REQ - 1);
  localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_BURST);

  sched_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]    pick;
  logic [NUM_REQ-1:0]    cur_q;
  logic [NUM_REQ-1:0]    last_q;
  logic [LEN_W-1:0]      cnt_q;
  logic [LEN_W-1:0]      win_len;
  logic [LEN_W-1:0]      win_len_sat;
  logic [ITEM_WIDTH-1:0] cur_a, cur_b;
  logic                  cur_valid;
  logic                  xfer;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req      (req_i),
    .last_gnt (last_q),
    .gnt      (pick)
  );

  // One-hot muxes: length of the new winner, operands of the current owner.
  always_comb begin
    win_len   = '0;
    cur_a     = '0;
    cur_b     = '0;
    cur_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) win_len = len_i[i*LEN_W +: LEN_W];
      if (cur_q[i]) begin
        cur_a     = item_a_i[i*ITEM_WIDTH +: ITEM_WIDTH];
        cur_b     = item_b_i[i*ITEM_WIDTH +: ITEM_WIDTH];
        cur_valid = item_valid_i[i];
      end
    end
    win_len_sat = (win_len > LEN_MAX) ? LEN_MAX : win_len;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    gnt_o        = '0;
    item_ready_o = '0;
    done_o       = '0;
    xfer         = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_i) state_d = (win_len_sat == '0) ? DONE : XMIT;
      end
      XMIT: begin
        gnt_o        = cur_q;
        item_ready_o = cur_q;
        xfer         = cur_valid;
        if (xfer && cnt_q == LEN_W'(1)) state_d = DONE;
      end
      DONE: begin
        done_o  = cur_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cur_q      <= '0;
      last_q     <= LAST_RST;
      cnt_q      <= '0;
      A_s        <= '0;
      B_s        <= '0;
      dp_valid_o <= 1'b0;
    end else begin
      dp_valid_o <= xfer;
      if (xfer) begin
        A_s   <= cur_a;
        B_s   <= cur_b;
        cnt_q <= cnt_q - LEN_W'(1);
      end
      if (state_q == IDLE && |req_i) begin
        cur_q <= pick;
        cnt_q <= win_len_sat;
      end
      if (state_q == DONE) last_q <= cur_q;
    end
  end

endmodule

// File: tb/tb_bfm_xmit_sched.sv
// Directed and randomized bursts against a burst-level model of the scheduler.
module tb_bfm_xmit_sched;

  localparam int NR = 2;
  localparam int MB = 100;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [1:0]  req_i;
  logic [13:0] len_i;
  logic [1:0]  gnt_o;
  logic [1:0]  item_valid_i;
  logic [15:0] item_a_i;
  logic [15:0] item_b_i;
  logic [1:0]  item_ready_o;
  logic [1:0]  done_o;
  logic [7:0]  A_s;
  logic [7:0]  B_s;
  logic        dp_valid_o;
  logic        busy_o;

  int         n_pass  = 0;
  int         n_total = 0;
  int         last_srv;
  logic [7:0] m_a;
  logic [7:0] m_b;

  bfm_xmit_sched #(.NUM_REQ(2), .ITEM_WIDTH(8), .MAX_BURST(100)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .req_i        (req_i),
    .len_i        (len_i),
    .gnt_o        (gnt_o),
    .item_valid_i (item_valid_i),
    .item_a_i     (item_a_i),
    .item_b_i     (item_b_i),
    .item_ready_o (item_ready_o),
    .done_o       (done_o),
    .A_s          (A_s),
    .B_s          (B_s),
    .dp_valid_o   (dp_valid_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Round-robin rule: first requester after the last one served, wrapping.
  function automatic int rr_model(input logic [1:0] req, input int last);
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (last + k) % NR;
      if (((req >> i) & 2'b01) != 2'b00) return i;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   32'(gnt_o),        32'd0);
    check({tag, "_ready"}, 32'(item_ready_o), 32'd0);
    check({tag, "_done"},  32'(done_o),       32'd0);
    check({tag, "_dpv"},   32'(dp_valid_o),   32'd0);
    check({tag, "_busy"},  32'(busy_o),       32'd0);
    check({tag, "_A"},     32'(A_s),          32'd0);
    check({tag, "_B"},     32'(B_s),          32'd0);
  endtask

  task automatic do_reset();
    reset_i      = 1'b1;
    req_i        = '0;
    len_i        = '0;
    item_valid_i = '0;
    item_a_i     = '0;
    item_b_i     = '0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    reset_i  = 1'b0;
    last_srv = NR - 1;
    m_a      = '0;
    m_b      = '0;
    @(negedge clk_i);
    check("post_reset_busy", 32'(busy_o), 32'd0);
  endtask

  // mode 0: valid always high, 1: random valid, 2: valid low on loop cycles 1 and 2.
  task automatic run_burst(input logic [1:0] req, input int l0, input int l1,
                           input int mode, input bit seq, input bit hold,
                           input int abort_at);
    int         w, n, sent, k;
    logic       v;
    logic [1:0] wb;
    w  = rr_model(req, last_srv);
    n  = (w == 0) ? l0 : l1;
    if (n > MB) n = MB;
    wb = 2'(1 << w);
    req_i = req;
    len_i = {7'(l1), 7'(l0)};
    @(negedge clk_i);
    check("grant", 32'(gnt_o), (n > 0) ? 32'(wb) : 32'd0);
    check("busy_at_grant", 32'(busy_o), 32'd1);
    if (!hold) req_i = '0;
    sent = 0;
    k    = 0;
    while (sent < n) begin
      if (sent == abort_at) begin
        reset_i      = 1'b1;
        item_valid_i = '0;
        req_i        = '0;
        @(negedge clk_i);
        check_all_zero("abort");
        reset_i  = 1'b0;
        last_srv = NR - 1;
        m_a      = '0;
        m_b      = '0;
        @(negedge clk_i);
        check("abort_no_done", 32'(done_o), 32'd0);
        check("abort_idle", 32'(busy_o), 32'd0);
        return;
      end
      if (k >= 400) begin
        check("burst_timeout", 32'(sent), 32'(n));
        break;
      end
      check("ready", 32'(item_ready_o), 32'(wb));
      check("gnt_hold", 32'(gnt_o), 32'(wb));
      case (mode)
        0:       v = 1'b1;
        2:       v = !(k == 1 || k == 2);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      item_valid_i = 2'($urandom);
      item_a_i     = 16'($urandom);
      item_b_i     = 16'($urandom);
      if (seq) begin
        if (w == 0) begin
          item_a_i[7:0] = 8'(2 * sent + 1);
          item_b_i[7:0] = 8'(2 * sent + 2);
        end else begin
          item_a_i[15:8] = 8'(2 * sent + 1);
          item_b_i[15:8] = 8'(2 * sent + 2);
        end
      end
      if (w == 0) item_valid_i[0] = v;
      else        item_valid_i[1] = v;
      if (v) begin
        m_a = (w == 0) ? item_a_i[7:0] : item_a_i[15:8];
        m_b = (w == 0) ? item_b_i[7:0] : item_b_i[15:8];
        sent++;
      end
      @(negedge clk_i);
      check("dp_valid", 32'(dp_valid_o), 32'(v));
      check("A_s", 32'(A_s), 32'(m_a));
      check("B_s", 32'(B_s), 32'(m_b));
      k++;
    end
    item_valid_i = '0;
    check("done", 32'(done_o), 32'(wb));
    check("gnt_in_done", 32'(gnt_o), 32'd0);
    check("ready_in_done", 32'(item_ready_o), 32'd0);
    check("busy_in_done", 32'(busy_o), 32'd1);
    if (n == 0) check("dp_valid_len0", 32'(dp_valid_o), 32'd0);
    last_srv = w;
    @(negedge clk_i);
    check("done_one_cycle", 32'(done_o), 32'd0);
    check("idle_busy", 32'(busy_o), 32'd0);
    check("idle_gnt", 32'(gnt_o), 32'd0);
    check("idle_dp_valid", 32'(dp_valid_o), 32'd0);
    check("idle_A_hold", 32'(A_s), 32'(m_a));
    check("idle_B_hold", 32'(B_s), 32'(m_b));
  endtask

  initial begin
    do_reset();

    // Single requester, length 3, operands (1,2),(3,4),(5,6).
    run_burst(2'b01, 3, 0, 0, 1'b1, 1'b0, -1);

    // Simultaneous requests from reset: requester 0 then 1, gap of 2 after done.
    do_reset();
    run_burst(2'b11, 2, 2, 0, 1'b0, 1'b1, -1);
    run_burst(2'b11, 2, 2, 0, 1'b0, 1'b0, -1);

    // Fairness with both requests held across four bursts.
    for (int b = 0; b < 4; b++)
      run_burst(2'b11, $urandom_range(1, 6), $urandom_range(1, 6), 1, 1'b0,
                (b < 3), -1);

    // Stall mid-burst, then a zero-length burst.
    run_burst(2'b01, 4, 0, 2, 1'b0, 1'b0, -1);
    run_burst(2'b10, 5, 0, 0, 1'b0, 1'b0, -1);

    // Reset after 50 of 100 pairs; next grant must return to requester 0.
    run_burst(2'b01, 100, 0, 0, 1'b0, 1'b0, 50);
    run_burst(2'b11, 3, 3, 0, 1'b0, 1'b0, -1);

    // Oversized length saturates to the maximum burst.
    run_burst(2'b10, 0, 127, 1, 1'b0, 1'b0, -1);

    // Randomized mix of requests and lengths.
    for (int r = 0; r < 8; r++)
      run_burst(2'($urandom_range(1, 3)), $urandom_range(0, 12),
                $urandom_range(0, 12), 1, 1'b0, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bfm_xmit_sched.md
BFM_XMIT_SCHED -- requirements
Module: bfm_xmit_sched

Interface
REQ-001 Parameter NUM_REQ, default 2; number of burst requesters.
REQ-002 Parameter ITEM_WIDTH, default 8; operand width.
REQ-003 Parameter MAX_BURST, default 100; maximum operand pairs per burst. LEN_W = clog2(MAX_BURST+1).
REQ-004 clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 req_i  in  NUM_REQ  per-requester burst request level.
REQ-007 len_i  in  NUM_REQ*LEN_W  per-requester burst length, sampled at grant.
REQ-008 gnt_o  out  NUM_REQ  one-hot grant, held for the whole burst.
REQ-009 item_valid_i  in  NUM_REQ  per-requester operand-pair valid.
REQ-010 item_a_i, item_b_i  in  NUM_REQ*ITEM_WIDTH each  per-requester operands.
REQ-011 item_ready_o  out  NUM_REQ  per-requester accept.
REQ-012 done_o  out  NUM_REQ  one-cycle burst-complete pulse.
REQ-013 A_s, B_s  out  ITEM_WIDTH each  registered operands to the bfm datapath.
REQ-014 dp_valid_o  out  1  A_s/B_s carry a new pair this cycle.
REQ-015 busy_o  out  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, XMIT and DONE.
REQ-017 IDLE: if any req_i bit is high, pick the winner round-robin, starting at the index after last_gnt. Next cycle: state XMIT, gnt_o one-hot on winner, count loaded with len_i of winner.
REQ-018 A winner len_i of 0 SHALL go IDLE->DONE directly, with no item transfer.
REQ-019 A len_i above MAX_BURST SHALL saturate to MAX_BURST.
REQ-020 XMIT: item_ready_o SHALL be high only for the granted index. All other item_ready_o bits SHALL be 0.
REQ-021 Transfer = item_valid_i[g] and item_ready_o[g] in the same cycle. On the next cycle A_s/B_s take the operands and dp_valid_o=1 for exactly one cycle; count decrements.
REQ-022 With valid held high, one pair SHALL transfer per cycle (no bubbles). Valid low stalls with no transfer and A_s/B_s held.
REQ-023 The transfer that brings count to 0 SHALL move the FSM to DONE. item_ready_o SHALL drop in the same edge.
REQ-024 DONE lasts one cycle: done_o[g]=1, gnt_o=0, last_gnt<=g, then IDLE.
REQ-025 req_i SHALL be sampled only in IDLE. Deasserting req_i mid-burst does not abort the burst. A req_i still high after DONE competes again under round-robin.
REQ-026 Arbitration latency from req_i high in IDLE to gnt_o high SHALL be 1 cycle. A grant to the next requester therefore follows done_o by 2 cycles.
REQ-027 A_s/B_s SHALL hold their last value when dp_valid_o=0.

Reset
REQ-028 reset_i high at a clock edge SHALL force, from any state including mid-burst:
- state IDLE
- gnt_o, item_ready_o, done_o, dp_valid_o, busy_o = 0
- A_s, B_s = 0
- count = 0
- last_gnt = NUM_REQ-1, so requester 0 wins first.
REQ-029 A burst interrupted by reset SHALL NOT produce done_o.

Structure
REQ-030 Package bfm_sched_pkg SHALL hold the FSM state enum and the LEN_W computation function.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_arbiter taking req and last_gnt and returning a one-hot pick. This module instantiates it once.

Verification
REQ-032 Single request: req_i=01, len 3, valid always high -> gnt_o=01 one cycle later; dp_valid_o for 3 consecutive cycles with operands (1,2),(3,4),(5,6); done_o=01 once; busy_o low afterwards.
REQ-033 Simultaneous: req_i=11 from reset, both len 2 -> requester 0 served first, then requester 1. Second grant follows done_o[0] by 2 cycles.
REQ-034 Fairness: both requests held high for 4 bursts -> grant order 0,1,0,1.
REQ-035 Stall and zero-length:
- valid low for 2 cycles mid-burst of 4 -> 4 dp_valid_o pulses total; A_s/B_s held during the stall.
- len 0 -> done_o with no dp_valid_o.
REQ-036 Reset and saturation:
- reset_i asserted after 50 of 100 pairs -> all outputs 0 next cycle; no done_o; next grant goes to requester 0.
- len_i=127 -> exactly 100 transfers.
